game_session_controller: RTL and testbench
==========================================

// Module: game_session_controller
// PURPOSE
// Produces the game-status flags (gameOver, gameFinished) that the end-of-play
// combiner consumes, plus the player-facing counters they derive from.
// Tracks lives, current level and a per-level countdown. Turns raw collision
// levels and level-complete pulses into a session state machine.
// Sits between the object/collision logic and the end-of-play/display logic.
// PARAMETERS
// LIVES       default 3   lives at session start (1..7)
// LEVELS      default 4   number of levels; clearing the last one wins (1..8)
// TIME_LIMIT  default 60  seconds per level, reloaded on each level entry (1..255)
// COOLDOWN    default 2   seconds of invulnerability after a hit (1..15)
// PORTS
// clk           in   1          system clock
// reset_n       in   1          asynchronous, active-low reset
// start         in   1          1-cycle pulse from debounced button
// collision     in   1          level signal, high while player overlaps obstacle
// levelDone     in   1          1-cycle pulse, player reached level goal
// secTick       in   1          1-cycle pulse once per second
// playing       out  1          high in PLAY or HIT
// hitFlash      out  1          high in HIT (display blink enable)
// gameOver      out  1          high in LOST
// gameFinished  out  1          high in WON
// livesLeft     out  3          remaining lives
// level         out  3          current level index, 0-based
// timeLeft      out  8          seconds remaining in current level
// BEHAVIOUR
// - All outputs registered; every update is visible the cycle after the causing input edge.
// - Reset (async, reset_n=0): state=IDLE, livesLeft=LIVES, level=0, timeLeft=TIME_LIMIT.
//   Reset also clears cooldown counter and collision edge register; all flags are 0.
// - Reset mid-session returns to IDLE immediately, with no cleanup cycle.
// - States: IDLE, PLAY, HIT, WON, LOST.
// - IDLE: start -> PLAY with full reload (lives, level 0, timeLeft=TIME_LIMIT).
// - PLAY: a hit is a rising edge of collision, detected against a 1-cycle delayed copy.
//     Hit with livesLeft>1 -> livesLeft-1, cooldown=COOLDOWN, go to HIT.
//     Hit with livesLeft==1 -> livesLeft=0, go to LOST.
//   levelDone with level==LEVELS-1 -> WON. Otherwise level+1, timeLeft=TIME_LIMIT, stay PLAY.
//   secTick: timeLeft-1. If timeLeft was 1 -> timeLeft=0, go to LOST.
// - HIT: collisions are ignored, including a collision held high into/through HIT.
//   secTick decrements both timeLeft and cooldown.
//   When cooldown reaches 0 -> PLAY. The edge register keeps tracking, so a still-high
//   collision does NOT re-hit on PLAY entry.
//   levelDone and timer expiry behave as in PLAY; cooldown is discarded.
// - Same-cycle priority (PLAY/HIT), highest first:
//   1. levelDone
//   2. hit
//   3. secTick expiry
//   A hit with a same-cycle secTick still decrements timeLeft; its expiry then wins only on the last life.
// - WON/LOST are sticky; counters freeze. start -> PLAY with full reload.
// - start in PLAY/HIT is ignored.
// - timeLeft never underflows below 0. level never exceeds LEVELS-1.
// - Bit widths of counters are fixed at the port widths; parameters beyond range are illegal.
// TESTING
// 1. Reset, then start -> playing=1 next cycle, livesLeft=3, level=0, timeLeft=60.
// 2. Collision held high 5 s from PLAY -> exactly one hit: livesLeft=2, hitFlash high 2 s,
//    then PLAY with no second hit.
// 3. Three separated collision edges -> livesLeft 2,1,0; gameOver=1 on the third; counters freeze.
// 4. levelDone x4 -> level 0..3 with timeLeft reloading to 60 each time, then gameFinished=1.
//    Then start -> fresh PLAY.
// 5. 60 secTicks without events -> timeLeft=0 and gameOver=1 in the cycle after the 60th tick.
//    levelDone on the same cycle as the 60th tick -> level advances instead.
// 6. reset_n low mid-HIT (asynchronous, not clock-aligned) -> all outputs at reset values
//    immediately; collision edge on first PLAY cycle after restart counts as a hit.

Source files
------------

// File: rtl/game_session_controller.sv
// Session FSM: lives, level and per-level countdown.
// Turns collision levels and level/second pulses into game flags.
module game_session_controller #(
  parameter int LIVES      = 3,
  parameter int LEVELS     = 4,
  parameter int TIME_LIMIT = 60,
  parameter int COOLDOWN   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       collision,
  input  logic       levelDone,
  input  logic       secTick,
  output logic       playing,
  output logic       hitFlash,
  output logic       gameOver,
  output logic       gameFinished,
  output logic [2:0] livesLeft,
  output logic [2:0] level,
  output logic [7:0] timeLeft
);

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    HIT,
    WON,
    LOST
  } state_t;

  localparam logic [2:0] LivesInit = 3'(LIVES);
  localparam logic [2:0] LastLevel = 3'(LEVELS - 1);
  localparam logic [7:0] TimeInit  = 8'(TIME_LIMIT);
  localparam logic [3:0] CoolInit  = 4'(COOLDOWN);

  state_t     state;
  state_t     stateNext;
  logic [2:0] livesNext;
  logic [2:0] levelNext;
  logic [7:0] timeNext;
  logic [7:0] timeDec;
  logic [3:0] cool;
  logic [3:0] coolNext;
  logic       collD;
  logic       hit;
  logic       expire;

  // State, counters, edge register and decoded flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      livesLeft    <= LivesInit;
      level        <= '0;
      timeLeft     <= TimeInit;
      cool         <= '0;
      collD        <= 1'b0;
      playing      <= 1'b0;
      hitFlash     <= 1'b0;
      gameOver     <= 1'b0;
      gameFinished <= 1'b0;
    end else begin
      state        <= stateNext;
      livesLeft    <= livesNext;
      level        <= levelNext;
      timeLeft     <= timeNext;
      cool         <= coolNext;
      collD        <= collision;
      playing      <= (stateNext == PLAY) || (stateNext == HIT);
      hitFlash     <= (stateNext == HIT);
      gameOver     <= (stateNext == LOST);
      gameFinished <= (stateNext == WON);
    end
  end

  // Next state and counters; levelDone beats hit beats expiry.
  always_comb begin
    stateNext = state;
    livesNext = livesLeft;
    levelNext = level;
    timeNext  = timeLeft;
    coolNext  = cool;
    hit       = (state == PLAY) && collision && !collD;
    expire    = secTick && (timeLeft <= 8'd1);
    timeDec   = timeLeft;
    if (secTick && (timeLeft != 8'd0)) begin
      timeDec = timeLeft - 8'd1;
    end
    case (state)
      PLAY, HIT: begin
        if (levelDone) begin
          coolNext = '0;
          if (level == LastLevel) begin
            stateNext = WON;
          end else begin
            stateNext = PLAY;
            levelNext = level + 3'd1;
            timeNext  = TimeInit;
          end
        end else if (hit) begin
          timeNext = timeDec;
          if (livesLeft > 3'd1) begin
            livesNext = livesLeft - 3'd1;
            coolNext  = CoolInit;
            stateNext = HIT;
          end else begin
            livesNext = '0;
            stateNext = LOST;
          end
        end else if (expire) begin
          timeNext  = '0;
          coolNext  = '0;
          stateNext = LOST;
        end else begin
          timeNext = timeDec;
          if ((state == HIT) && secTick) begin
            if (cool != 4'd0) begin
              coolNext = cool - 4'd1;
            end
            if (cool <= 4'd1) begin
              stateNext = PLAY;
            end
          end
        end
      end
      default: begin
        if (start) begin
          stateNext = PLAY;
          livesNext = LivesInit;
          levelNext = '0;
          timeNext  = TimeInit;
          coolNext  = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_game_session_controller.sv
// Bench for game_session_controller: vector table,
// expected-output queue, timer loops and async reset.
module tb_game_session_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic       levelDone = 1'b0;
  logic       secTick = 1'b0;
  logic       playing;
  logic       hitFlash;
  logic       gameOver;
  logic       gameFinished;
  logic [2:0] livesLeft;
  logic [2:0] level;
  logic [7:0] timeLeft;

  game_session_controller dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .collision(collision),
    .levelDone(levelDone),
    .secTick(secTick),
    .playing(playing),
    .hitFlash(hitFlash),
    .gameOver(gameOver),
    .gameFinished(gameFinished),
    .livesLeft(livesLeft),
    .level(level),
    .timeLeft(timeLeft)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       st;
    logic       col;
    logic       ld;
    logic       tk;
    logic [17:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] expQ[$];
  string       nameQ[$];
  vec_t        tbl[$];
  logic [17:0] act;

  assign act = {playing, hitFlash, gameOver, gameFinished,
                livesLeft, level, timeLeft};

  function automatic logic [17:0] pk(
    logic pl, logic hf, logic go, logic gf,
    logic [2:0] lv, logic [2:0] lvl, logic [7:0] tl);
    return {pl, hf, go, gf, lv, lvl, tl};
  endfunction

  function automatic vec_t mk(
    string n, logic st, logic col, logic ld, logic tk,
    logic [17:0] e);
    vec_t v;
    v.name = n;
    v.st   = st;
    v.col  = col;
    v.ld   = ld;
    v.tk   = tk;
    v.exp  = e;
    return v;
  endfunction

  task automatic check(string n, logic [17:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got pl=%b hf=%b go=%b gf=%b lives=%0d lvl=%0d t=%0d want pl=%b hf=%b go=%b gf=%b lives=%0d lvl=%0d t=%0d",
        n, act[17], act[16], act[15], act[14], act[13:11],
        act[10:8], act[7:0], e[17], e[16], e[15], e[14],
        e[13:11], e[10:8], e[7:0]);
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    start     = v.st;
    collision = v.col;
    levelDone = v.ld;
    secTick   = v.tk;
    expQ.push_back(v.exp);
    nameQ.push_back(v.name);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      check(nameQ.pop_front(), expQ.pop_front());
    end
  endtask

  initial begin
    tbl.push_back(mk("idle",      0,0,0,0, pk(0,0,0,0,3,0,60)));
    tbl.push_back(mk("start",     1,0,0,0, pk(1,0,0,0,3,0,60)));
    tbl.push_back(mk("startIgn",  1,0,0,1, pk(1,0,0,0,3,0,59)));
    tbl.push_back(mk("hitRise",   0,1,0,0, pk(1,1,0,0,2,0,59)));
    tbl.push_back(mk("hitHold1",  0,1,0,1, pk(1,1,0,0,2,0,58)));
    tbl.push_back(mk("hitHold2",  0,1,0,0, pk(1,1,0,0,2,0,58)));
    tbl.push_back(mk("hitEnd",    0,1,0,1, pk(1,0,0,0,2,0,57)));
    tbl.push_back(mk("noRehit1",  0,1,0,1, pk(1,0,0,0,2,0,56)));
    tbl.push_back(mk("noRehit2",  0,1,0,1, pk(1,0,0,0,2,0,55)));
    tbl.push_back(mk("colLow",    0,0,0,0, pk(1,0,0,0,2,0,55)));
    tbl.push_back(mk("hit2",      0,1,0,0, pk(1,1,0,0,1,0,55)));
    tbl.push_back(mk("hit2Tick",  0,0,0,1, pk(1,1,0,0,1,0,54)));
    tbl.push_back(mk("hit2Ign",   0,1,0,0, pk(1,1,0,0,1,0,54)));
    tbl.push_back(mk("hit2End",   0,1,0,1, pk(1,0,0,0,1,0,53)));
    tbl.push_back(mk("colLow2",   0,0,0,0, pk(1,0,0,0,1,0,53)));
    tbl.push_back(mk("lastHit",   0,1,0,0, pk(0,0,1,0,0,0,53)));
    tbl.push_back(mk("lostFrz",   0,0,1,1, pk(0,0,1,0,0,0,53)));
    tbl.push_back(mk("lostStart", 1,0,0,0, pk(1,0,0,0,3,0,60)));
    tbl.push_back(mk("tick",      0,0,0,1, pk(1,0,0,0,3,0,59)));
    tbl.push_back(mk("lvl1",      0,0,1,0, pk(1,0,0,0,3,1,60)));
    tbl.push_back(mk("lvl2Tick",  0,0,1,1, pk(1,0,0,0,3,2,60)));
    tbl.push_back(mk("tick2",     0,0,0,1, pk(1,0,0,0,3,2,59)));
    tbl.push_back(mk("ldOverHit", 0,1,1,0, pk(1,0,0,0,3,3,60)));
    tbl.push_back(mk("colDrop",   0,0,0,0, pk(1,0,0,0,3,3,60)));
    tbl.push_back(mk("hitTick",   0,1,0,1, pk(1,1,0,0,2,3,59)));
    tbl.push_back(mk("wonInHit",  0,0,1,0, pk(0,0,0,1,2,3,59)));
    tbl.push_back(mk("wonFrz",    0,1,1,1, pk(0,0,0,1,2,3,59)));
    tbl.push_back(mk("wonStart",  1,0,0,0, pk(1,0,0,0,3,0,60)));

    repeat (2) @(negedge clk);
    check("resetVals", pk(0,0,0,0,3,0,60));
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    for (int i = 1; i < 60; i++) begin
      apply(mk("countdown", 0,0,0,1,
        pk(1,0,0,0,3,0,8'(60 - i))));
    end
    apply(mk("expire", 0,0,0,1, pk(0,0,1,0,3,0,0)));
    apply(mk("expFrz", 0,0,0,1, pk(0,0,1,0,3,0,0)));
    apply(mk("restart", 1,0,0,0, pk(1,0,0,0,3,0,60)));
    for (int i = 1; i < 60; i++) begin
      apply(mk("countdown2", 0,0,0,1,
        pk(1,0,0,0,3,0,8'(60 - i))));
    end
    apply(mk("ldAtExpire", 0,0,1,1, pk(1,0,0,0,3,1,60)));

    apply(mk("preRstHit", 0,1,0,0, pk(1,1,0,0,2,1,60)));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("asyncRst", pk(0,0,0,0,3,0,60));
    start     = 1'b0;
    collision = 1'b0;
    levelDone = 1'b0;
    secTick   = 1'b0;
    repeat (2) @(negedge clk);
    check("rstHold", pk(0,0,0,0,3,0,60));
    reset_n = 1'b1;
    apply(mk("idleAfter", 0,0,0,0, pk(0,0,0,0,3,0,60)));
    apply(mk("start3",    1,0,0,0, pk(1,0,0,0,3,0,60)));
    apply(mk("firstHit",  0,1,0,0, pk(1,1,0,0,2,0,60)));

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sbDrain: got %0d left want 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
